// File: rtl/i2c_target_regfile_if.sv
// Purpose: bundles the I2C pins and register-file write strobe of i2c_target_regfile.
// Latency: none; this is wiring only.
// Backpressure: none; wr_vld_o is a fire-and-forget pulse and SCL is never stretched.
// Ports: scl_i/sda_i  wired-AND bus levels into the target
//        scl_o/sda_o  open-drain drives (1 = release)
//        busy_o       target is addressed
//        wr_vld_o/wr_idx_o/wr_dat_o  one-cycle notice of each stored byte
// Modports: slave = the target, master = whatever drives the bus and watches the strobe.
interface i2c_target_regfile_if #(
  parameter int IDX_W = 4,
  parameter int DAT_W = 8
);
  logic             scl_i;
  logic             sda_i;
  logic             scl_o;
  logic             sda_o;
  logic             busy_o;
  logic             wr_vld_o;
  logic [IDX_W-1:0] wr_idx_o;
  logic [DAT_W-1:0] wr_dat_o;

  modport slave (
    input  scl_i, sda_i,
    output scl_o, sda_o, busy_o, wr_vld_o, wr_idx_o, wr_dat_o
  );

  modport master (
    output scl_i, sda_i,
    input  scl_o, sda_o, busy_o, wr_vld_o, wr_idx_o, wr_dat_o
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// Purpose: I2C target at a fixed 7-bit address that fronts a byte register file.
// Latency: bus pins reach the FSM 3 clk_i cycles late; SDA drive updates 1 cycle after a seen SCL fall.
// Backpressure: none; never stretches SCL, and the write strobe cannot be stalled.
// Ports: clk_i  system clock (>= 16x SCL)
//        rst_i  asynchronous active-high reset
//        bus    i2c_target_regfile_if.slave (pins, busy_o, write strobe)
module i2c_target_regfile #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] TARGET_ADDR    = 7'h22,
  parameter int                        MEM_DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  i2c_target_regfile_if.slave   bus
);

  localparam int         IDX_W     = $clog2(MEM_DEPTH);
  localparam int         MSB       = I2C_DATA_WIDTH - 1;
  localparam logic [3:0] BYTE_BITS = 4'(I2C_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, A_ACK, RX, D_ACK, TX, M_ACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  // Synchronizers plus one history flop per line for edge detection.
  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]          bit_cnt;   // SCL rising edges seen in the current phase
  logic [MSB:0]        shreg;
  logic [IDX_W-1:0]    ptr;
  logic [MSB:0]        mem [MEM_DEPTH];
  logic                first_q;   // next RX byte is the pointer byte
  logic                ack_bit_q; // controller's ACK/NACK after a TX byte
  logic                sda_o_q;
  logic                wr_vld_q;
  logic [IDX_W-1:0]    wr_idx_q;
  logic [MSB:0]        wr_dat_q;

  logic sda_d, cnt_clr, ld_tx, tx_shift, ptr_set, ptr_inc, mem_wr, first_set;

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  =  scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s &  scl_prev;
  // SCL must be high on both samples so an SDA change near an SCL edge is not mistaken for START/STOP.
  assign start_det = scl_s & scl_prev &  sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev &  sda_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Every SDA change is keyed to a detected SCL fall, so the line stays put while SCL is high.
  // START/STOP can only be seen while the target releases SDA, so forcing 1 there is safe.
  always_comb begin
    state_d   = state_q;
    sda_d     = sda_o_q;
    cnt_clr   = 1'b0;
    ld_tx     = 1'b0;
    tx_shift  = 1'b0;
    ptr_set   = 1'b0;
    ptr_inc   = 1'b0;
    mem_wr    = 1'b0;
    first_set = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      cnt_clr = 1'b1;
    end else if (start_det) begin
      state_d = ADDR;
      sda_d   = 1'b1;
      cnt_clr = 1'b1;
    end else if (scl_fall) begin
      unique case (state_q)
        ADDR: if (bit_cnt == BYTE_BITS) begin
          cnt_clr = 1'b1;
          if (shreg[MSB -: I2C_ADDR_WIDTH] == TARGET_ADDR) begin
            state_d = A_ACK;
            sda_d   = 1'b0;
          end else begin
            state_d = IGNORE;
            sda_d   = 1'b1;
          end
        end
        A_ACK: if (bit_cnt == 4'd1) begin
          cnt_clr = 1'b1;
          if (shreg[0]) begin  // R/W bit still sits in the LSB
            state_d = TX;
            ld_tx   = 1'b1;
            sda_d   = mem[ptr][MSB];
          end else begin
            state_d   = RX;
            sda_d     = 1'b1;
            first_set = 1'b1;
          end
        end
        RX: if (bit_cnt == BYTE_BITS) begin
          cnt_clr = 1'b1;
          state_d = D_ACK;
          sda_d   = 1'b0;
          if (first_q) begin
            ptr_set = 1'b1;
          end else begin
            mem_wr  = 1'b1;
            ptr_inc = 1'b1;
          end
        end
        D_ACK: if (bit_cnt == 4'd1) begin
          cnt_clr = 1'b1;
          state_d = RX;
          sda_d   = 1'b1;
        end
        TX: if (bit_cnt == BYTE_BITS) begin
          cnt_clr = 1'b1;
          state_d = M_ACK;
          sda_d   = 1'b1;
          ptr_inc = 1'b1;
        end else if (bit_cnt != 4'd0) begin
          sda_d    = shreg[MSB-1];
          tx_shift = 1'b1;
        end
        M_ACK: if (bit_cnt == 4'd1) begin
          cnt_clr = 1'b1;
          if (!ack_bit_q) begin
            state_d = TX;
            ld_tx   = 1'b1;
            sda_d   = mem[ptr][MSB];
          end else begin
            state_d = IGNORE;
            sda_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      first_q   <= 1'b0;
      ack_bit_q <= 1'b1;
      sda_o_q   <= 1'b1;
      wr_vld_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_dat_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_vld_q <= 1'b0;
      sda_o_q  <= sda_d;

      // Saturate so long idle stretches cannot wrap the counter into a false match.
      if (cnt_clr)                          bit_cnt <= '0;
      else if (scl_rise && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;

      if (scl_rise) begin
        if (state_q == ADDR || state_q == RX) shreg <= {shreg[MSB-1:0], sda_s};
        if (state_q == M_ACK)                 ack_bit_q <= sda_s;
      end
      if (ld_tx)    shreg <= mem[ptr];
      if (tx_shift) shreg <= {shreg[MSB-1:0], 1'b1};

      if (first_set)    first_q <= 1'b1;
      else if (ptr_set) first_q <= 1'b0;

      if (ptr_set)      ptr <= shreg[IDX_W-1:0];
      else if (ptr_inc) ptr <= ptr + IDX_W'(1);

      if (mem_wr) begin
        mem[ptr] <= shreg;
        wr_vld_q <= 1'b1;
        wr_idx_q <= ptr;
        wr_dat_q <= shreg;
      end
    end
  end

  assign bus.scl_o    = 1'b1;
  assign bus.sda_o    = sda_o_q;
  assign bus.busy_o   = (state_q == A_ACK) || (state_q == RX) || (state_q == D_ACK) ||
                        (state_q == TX)    || (state_q == M_ACK);
  assign bus.wr_vld_o = wr_vld_q;
  assign bus.wr_idx_o = wr_idx_q;
  assign bus.wr_dat_o = wr_dat_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Purpose: checks i2c_target_regfile against a byte-array model through an I2C controller driver.
// Latency: SCL quarter period is Q time units (8 clk_i cycles).
// Backpressure: none; the driver owns all bus timing.
module tb_i2c_target_regfile;
  localparam int         Q   = 80;
  localparam logic [6:0] TGT = 7'h22;

  typedef struct packed { logic [3:0] idx; logic [7:0] dat; } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int sda_glitch  = 0;
  int sda_low_cnt = 0;
  logic scl_prev   = 1'b1;
  logic sda_o_prev = 1'b1;

  logic [7:0] mem_m [16];
  int         ptr_m = 0;
  wr_t        got_q[$];
  wr_t        exp_q[$];

  always #5 clk = ~clk;

  i2c_target_regfile_if #(.IDX_W(4), .DAT_W(8)) bus ();
  assign bus.scl_i = scl_drv & bus.scl_o;
  assign bus.sda_i = sda_drv & bus.sda_o;

  i2c_target_regfile #(
    .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .TARGET_ADDR(7'h22), .MEM_DEPTH(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always @(negedge clk) begin
    if (bus.wr_vld_o === 1'b1) got_q.push_back({bus.wr_idx_o, bus.wr_dat_o});
    if (!rst && scl_prev && bus.scl_i && (bus.sda_o !== sda_o_prev)) sda_glitch <= sda_glitch + 1;
    if (bus.sda_o === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
    scl_prev   <= bus.scl_i;
    sda_o_prev <= bus.sda_o;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    ptr_m = 0;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [7:0] q[$]);
    wr_t w;
    if (a != TGT) return;
    foreach (q[i]) begin
      if (i == 0) begin
        ptr_m = int'(q[i] % 8'd16);
      end else begin
        w.idx = 4'(ptr_m);
        w.dat = q[i];
        exp_q.push_back(w);
        mem_m[ptr_m] = q[i];
        ptr_m = (ptr_m + 1) % 16;
      end
    end
  endtask

  // ---------------- bus driver ----------------
  task automatic i2c_start();
    sda_drv = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_drv = 1'b0; #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; #(Q);
    scl_drv = 1'b1; #(Q);
    sda_drv = 1'b1; #(2*Q);
  endtask

  task automatic wbit(input logic b);
    sda_drv = b;    #(Q);
    scl_drv = 1'b1; #(2*Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic rbit(output logic b);
    sda_drv = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    b = bus.sda_i;  #(Q);
    scl_drv = 1'b0; #(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] b, input logic nack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      rbit(v);
      b[i] = v;
    end
    wbit(nack);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] q[$], output int nacks);
    logic ack;
    nacks = 0;
    i2c_start();
    wbyte({a, 1'b0}, ack);
    nacks += int'(ack);
    foreach (q[i]) begin
      wbyte(q[i], ack);
      nacks += int'(ack);
    end
    i2c_stop();
  endtask

  task automatic do_ptr_read(input logic [7:0] p, input int n, output logic [7:0] rd[$],
                             output int nacks);
    logic ack;
    logic [7:0] b;
    rd.delete();
    nacks = 0;
    i2c_start();
    wbyte({TGT, 1'b0}, ack); nacks += int'(ack);
    wbyte(p, ack);           nacks += int'(ack);
    i2c_start();
    wbyte({TGT, 1'b1}, ack); nacks += int'(ack);
    for (int i = 0; i < n; i++) begin
      rbyte(b, (i == n - 1));
      rd.push_back(b);
    end
    i2c_stop();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (bus.sda_o !== 1'b1)    begin n_fail++; $display("FAIL reset_sda_o: got %b expected 1", bus.sda_o); end
    if (bus.scl_o !== 1'b1)    begin n_fail++; $display("FAIL reset_scl_o: got %b expected 1", bus.scl_o); end
    if (bus.busy_o !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    if (bus.wr_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_vld: got %b expected 0", bus.wr_vld_o); end
    if (bus.wr_idx_o !== 4'h0) begin n_fail++; $display("FAIL reset_wr_idx: got %h expected 0", bus.wr_idx_o); end
    if (bus.wr_dat_o !== 8'h00) begin n_fail++; $display("FAIL reset_wr_dat: got %h expected 00", bus.wr_dat_o); end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.sda_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: sda_o=%b busy=%b expected 1/0", bus.sda_o, bus.busy_o);
    end
    model_reset();
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    logic [7:0] rd[$];
    logic [7:0] aw;
    logic ack;
    int nacks;
    q.push_back(8'h02);
    for (int i = 0; i < 4; i++) q.push_back(8'($urandom_range(1, 255)));
    do_write(TGT, q, nacks);
    model_write(TGT, q);
    n_checks++;
    if (nacks !== 0) begin n_fail++; $display("FAIL prefill_acks: got %0d nacks expected 0", nacks); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL prefill_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL prefill_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();

    // Reset while SCL is high in the middle of a data byte.
    i2c_start();
    wbyte({TGT, 1'b0}, ack);
    wbyte(8'h06, ack);
    for (int i = 0; i < 3; i++) wbit(1'($urandom_range(0, 1)));
    sda_drv = 1'b0; #(Q);
    scl_drv = 1'b1; #(Q);
    n_checks++;
    if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL mid_rx_busy: got %b expected 1", bus.busy_o); end
    rst = 1'b1; #1;
    n_checks++;
    if (bus.sda_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_rx_reset: sda_o=%b busy=%b expected 1/0", bus.sda_o, bus.busy_o);
    end
    reset_pulse();

    // Reset while the target holds SDA low for the address ACK.
    aw = {TGT, 1'b0};
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(aw[i]);
    sda_drv = 1'b1; #(Q);
    scl_drv = 1'b1; #(Q);
    n_checks++;
    if (bus.sda_o !== 1'b0) begin n_fail++; $display("FAIL ack_before_reset: sda_o=%b expected 0", bus.sda_o); end
    rst = 1'b1; #1;
    n_checks++;
    if (bus.sda_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      n_fail++; $display("FAIL mid_ack_reset: sda_o=%b busy=%b expected 1/0", bus.sda_o, bus.busy_o);
    end
    reset_pulse();

    do_ptr_read(8'h00, 16, rd, nacks);
    n_checks++;
    if (nacks !== 0) begin n_fail++; $display("FAIL readback_acks: got %0d nacks expected 0", nacks); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd[i] !== mem_m[i]) begin n_fail++; $display("FAIL readback[%0d]: got %h expected %h", i, rd[i], mem_m[i]); end
    end
    ptr_m = 0;
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL readback_no_wr: got %0d strobes expected 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_write_basic();
    logic [7:0] q[$];
    logic [7:0] b;
    logic ack;
    int nacks;
    q.push_back(8'h05); q.push_back(8'hC3);
    do_write(TGT, q, nacks);
    model_write(TGT, q);
    got_q.delete(); exp_q.delete();

    q.delete(); q.push_back(8'h03); q.push_back(8'hA5); q.push_back(8'h5A);
    i2c_start();
    wbyte({TGT, 1'b0}, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b expected 0", ack); end
    n_checks++;
    if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", bus.busy_o); end
    foreach (q[i]) begin
      wbyte(q[i], ack);
      n_checks++;
      if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack[%0d]: got %b expected 0", i, ack); end
    end
    i2c_stop();
    model_write(TGT, q);
    n_checks++;
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL wr_busy_after_stop: got %b expected 0", bus.busy_o); end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wr_strobe[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();

    // Pointer now sits after the last byte; a plain read must start there.
    i2c_start();
    wbyte({TGT, 1'b1}, ack);
    rbyte(b, 1'b1);
    i2c_stop();
    n_checks++;
    if (b !== mem_m[ptr_m]) begin n_fail++; $display("FAIL ptr_after_write: got %h expected %h", b, mem_m[ptr_m]); end
    ptr_m = (ptr_m + 1) % 16;
  endtask

  task automatic test_read_rs();
    logic [7:0] b0, b1;
    logic ack;
    int nacks = 0;
    i2c_start();
    wbyte({TGT, 1'b0}, ack); nacks += int'(ack);
    wbyte(8'h03, ack);       nacks += int'(ack);
    i2c_start();
    wbyte({TGT, 1'b1}, ack); nacks += int'(ack);
    rbyte(b0, 1'b0);
    rbyte(b1, 1'b1);
    i2c_stop();
    n_checks += 4;
    if (nacks !== 0)      begin n_fail++; $display("FAIL rs_acks: got %0d nacks expected 0", nacks); end
    if (b0 !== mem_m[3])  begin n_fail++; $display("FAIL rs_byte0: got %h expected %h", b0, mem_m[3]); end
    if (b1 !== mem_m[4])  begin n_fail++; $display("FAIL rs_byte1: got %h expected %h", b1, mem_m[4]); end
    if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rs_busy_end: got %b expected 0", bus.busy_o); end
    ptr_m = 5;
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] rd[$];
    int nacks;
    q.push_back(8'h0F); q.push_back(8'h11); q.push_back(8'h22);
    do_write(TGT, q, nacks);
    model_write(TGT, q);
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_wr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_wr[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
    do_ptr_read(8'h0F, 2, rd, nacks);
    n_checks += 2;
    if (rd[0] !== mem_m[15]) begin n_fail++; $display("FAIL wrap_rd0: got %h expected %h", rd[0], mem_m[15]); end
    if (rd[1] !== mem_m[0])  begin n_fail++; $display("FAIL wrap_rd1: got %h expected %h", rd[1], mem_m[0]); end
    ptr_m = 1;
  endtask

  task automatic test_addr_miss();
    logic ack;
    logic [7:0] b;
    int low0;
    low0 = sda_low_cnt;
    i2c_start();
    wbyte({7'h23, 1'b0}, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL miss_addr_ack: got %b expected 1", ack); end
    wbyte(8'h77, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL miss_data_ack: got %b expected 1", ack); end
    i2c_stop();
    n_checks += 2;
    if (sda_low_cnt != low0) begin n_fail++; $display("FAIL miss_sda_low: got %0d low cycles expected 0", sda_low_cnt - low0); end
    if (got_q.size() != 0)   begin n_fail++; $display("FAIL miss_wr: got %0d strobes expected 0", got_q.size()); end
    got_q.delete();
    i2c_start();
    wbyte({TGT, 1'b1}, ack);
    rbyte(b, 1'b1);
    i2c_stop();
    n_checks += 2;
    if (ack !== 1'b0)        begin n_fail++; $display("FAIL miss_then_hit_ack: got %b expected 0", ack); end
    if (b !== mem_m[ptr_m])  begin n_fail++; $display("FAIL miss_then_hit_data: got %h expected %h", b, mem_m[ptr_m]); end
    ptr_m = (ptr_m + 1) % 16;
  endtask

  task automatic test_stop_mid();
    logic [7:0] q[$];
    logic [7:0] b;
    logic ack;
    i2c_start();
    wbyte({TGT, 1'b0}, ack);
    wbyte(8'h03, ack);
    for (int i = 0; i < 4; i++) wbit(1'($urandom_range(0, 1)));
    i2c_stop();
    q.push_back(8'h03);
    model_write(TGT, q);
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL stop_mid_wr: got %0d strobes expected 0", got_q.size()); end
    got_q.delete();
    i2c_start();
    wbyte({TGT, 1'b1}, ack);
    rbyte(b, 1'b1);
    i2c_stop();
    n_checks++;
    if (b !== mem_m[ptr_m]) begin n_fail++; $display("FAIL stop_mid_read: got %h expected %h", b, mem_m[ptr_m]); end
    ptr_m = (ptr_m + 1) % 16;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] rd[$];
    logic [6:0] a;
    logic [7:0] p;
    int nacks, exp_nacks, n;
    for (int it = 0; it < 6; it++) begin
      a = TGT;
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == TGT) a = 7'h23;
      end
      q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i <= n; i++) q.push_back(8'($urandom_range(0, 255)));
      do_write(a, q, nacks);
      model_write(a, q);
      exp_nacks = (a == TGT) ? 0 : n + 2;
      n_checks++;
      if (nacks != exp_nacks) begin n_fail++; $display("FAIL rnd_acks[%0d]: got %0d nacks expected %0d", it, nacks, exp_nacks); end
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++; $display("FAIL rnd_wr_count[%0d]: got %0d expected %0d", it, got_q.size(), exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_wr[%0d.%0d]: got %h expected %h", it, i, got_q[i], exp_q[i]); end
      end
      got_q.delete(); exp_q.delete();

      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      do_ptr_read(p, n, rd, nacks);
      ptr_m = int'(p % 8'd16);
      for (int i = 0; i < n; i++) begin
        n_checks++;
        if (rd[i] !== mem_m[ptr_m]) begin n_fail++; $display("FAIL rnd_rd[%0d.%0d]: got %h expected %h", it, i, rd[i], mem_m[ptr_m]); end
        ptr_m = (ptr_m + 1) % 16;
      end
    end
  endtask

  task automatic test_scl_high_stable();
    n_checks++;
    if (sda_glitch != 0) begin n_fail++; $display("FAIL sda_while_scl_high: got %0d changes expected 0", sda_glitch); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid();
    test_write_basic();
    test_read_rs();
    test_wrap();
    test_addr_miss();
    test_stop_mid();
    test_random();
    test_scl_high_stable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
